// File: rtl/codec_i2c_master.sv
// rtl/codec_i2c_master.sv - register-access I2C master for the audio codec control port
// One request at a time: write = dev/ptr/data, read = dev/ptr/rstart/dev+R/data/nack.
module codec_i2c_master #(
   parameter int unsigned CLK_DIV  = 250,
   parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       codec_rd_en,
   input  logic       codec_wr_en,
   input  logic [8:0] codec_reg_addr,
   input  logic [7:0] codec_wr_data,
   output logic [7:0] codec_rd_data,
   output logic       codec_rd_data_valid,
   output logic       controller_busy,
   output logic       xfer_done,
   output logic       ack_error,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_i
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RSTART,
      S_RX_BYTE, S_TX_NACK, S_STOP, S_DONE
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_div, w_div_nxt;
   logic [1:0]  r_q, w_q_nxt;
   logic [2:0]  r_bit, w_bit_nxt;
   logic [1:0]  r_byte, w_byte_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic [7:0]  r_addr, w_addr_nxt;
   logic [7:0]  r_wdata, w_wdata_nxt;
   logic        r_is_read, w_is_read_nxt;
   logic        r_nack, w_nack_nxt;
   logic        r_err, w_err_nxt;
   logic        r_scl_oe, w_scl_nxt;
   logic        r_sda_oe, w_sda_nxt;
   logic        r_busy, r_done, r_ack_err, r_rd_valid;
   logic [7:0]  r_rd_data;
   logic        w_done_nxt, w_rd_valid_nxt;
   logic        w_tick, w_sample, w_slot_end;
   logic        w_unused;

   // Pointer byte is only 8 bits wide on the wire; the top address bit is reserved.
   assign w_unused   = codec_reg_addr[8];
   assign w_tick     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_div == DIV_LAST);
   assign w_sample   = w_tick && (r_q == 2'd2);
   assign w_slot_end = w_tick && (r_q == 2'd3);

   always_comb begin
      w_state_nxt   = r_state;
      w_div_nxt     = '0;
      w_q_nxt       = r_q;
      w_bit_nxt     = r_bit;
      w_byte_nxt    = r_byte;
      w_shift_nxt   = r_shift;
      w_addr_nxt    = r_addr;
      w_wdata_nxt   = r_wdata;
      w_is_read_nxt = r_is_read;
      w_nack_nxt    = r_nack;
      w_err_nxt     = r_err;
      if (r_state != S_IDLE && r_state != S_DONE) begin
         w_div_nxt = w_tick ? 16'd0 : r_div + 16'd1;
      end
      if (w_tick) begin
         w_q_nxt = r_q + 2'd1;
      end
      case (r_state)
         S_IDLE: begin
            if (codec_wr_en || codec_rd_en) begin
               w_state_nxt   = S_START;
               w_q_nxt       = 2'd0;
               w_addr_nxt    = codec_reg_addr[7:0];
               w_wdata_nxt   = codec_wr_data;
               w_is_read_nxt = ~codec_wr_en;
               w_byte_nxt    = 2'd0;
               w_err_nxt     = 1'b0;
            end
         end
         S_START, S_RSTART: begin
            if (w_slot_end) begin
               w_state_nxt = S_TX_BYTE;
               w_bit_nxt   = 3'd7;
               w_shift_nxt = {DEV_ADDR, (r_state == S_RSTART)};
               w_byte_nxt  = (r_state == S_RSTART) ? 2'd2 : 2'd0;
            end
         end
         S_TX_BYTE: begin
            if (w_slot_end) begin
               if (r_bit == 3'd0) begin
                  w_state_nxt = S_RX_ACK;
               end else begin
                  w_bit_nxt   = r_bit - 3'd1;
                  w_shift_nxt = {r_shift[6:0], 1'b0};
               end
            end
         end
         S_RX_ACK: begin
            if (w_sample) begin
               w_nack_nxt = sda_i;
            end
            if (w_slot_end) begin
               w_bit_nxt = 3'd7;
               if (r_nack) begin
                  w_state_nxt = S_STOP;
                  w_err_nxt   = 1'b1;
               end else if (r_byte == 2'd0) begin
                  w_state_nxt = S_TX_BYTE;
                  w_byte_nxt  = 2'd1;
                  w_shift_nxt = r_addr;
               end else if (r_byte == 2'd1) begin
                  w_state_nxt = r_is_read ? S_RSTART : S_TX_BYTE;
                  w_byte_nxt  = 2'd2;
                  w_shift_nxt = r_wdata;
               end else begin
                  w_state_nxt = r_is_read ? S_RX_BYTE : S_STOP;
               end
            end
         end
         S_RX_BYTE: begin
            if (w_sample) begin
               w_shift_nxt = {r_shift[6:0], sda_i};
            end
            if (w_slot_end) begin
               if (r_bit == 3'd0) begin
                  w_state_nxt = S_TX_NACK;
               end else begin
                  w_bit_nxt = r_bit - 3'd1;
               end
            end
         end
         S_TX_NACK: begin
            if (w_slot_end) begin
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_slot_end) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      // Pins are derived from the upcoming state/quarter so the registered drive lands on the tick.
      w_scl_nxt = 1'b0;
      w_sda_nxt = 1'b0;
      case (w_state_nxt)
         S_START, S_RSTART: begin
            w_sda_nxt = w_q_nxt[1];
            w_scl_nxt = (w_q_nxt == 2'd3);
         end
         S_TX_BYTE: begin
            w_scl_nxt = ~w_q_nxt[1];
            w_sda_nxt = ~w_shift_nxt[7];
         end
         S_RX_ACK, S_RX_BYTE, S_TX_NACK: begin
            w_scl_nxt = ~w_q_nxt[1];
         end
         S_STOP: begin
            w_scl_nxt = (w_q_nxt == 2'd0);
            w_sda_nxt = ~w_q_nxt[1];
         end
         default: ;
      endcase

      w_done_nxt     = (w_state_nxt == S_DONE);
      w_rd_valid_nxt = w_done_nxt && r_is_read && !w_err_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_div      <= '0;
         r_q        <= '0;
         r_bit      <= '0;
         r_byte     <= '0;
         r_shift    <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_is_read  <= 1'b0;
         r_nack     <= 1'b0;
         r_err      <= 1'b0;
         r_scl_oe   <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ack_err  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_div      <= w_div_nxt;
         r_q        <= w_q_nxt;
         r_bit      <= w_bit_nxt;
         r_byte     <= w_byte_nxt;
         r_shift    <= w_shift_nxt;
         r_addr     <= w_addr_nxt;
         r_wdata    <= w_wdata_nxt;
         r_is_read  <= w_is_read_nxt;
         r_nack     <= w_nack_nxt;
         r_err      <= w_err_nxt;
         r_scl_oe   <= w_scl_nxt;
         r_sda_oe   <= w_sda_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_done     <= w_done_nxt;
         r_ack_err  <= w_done_nxt && w_err_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         if (w_rd_valid_nxt) begin
            r_rd_data <= r_shift;
         end
      end
   end

   assign codec_rd_data       = r_rd_data;
   assign codec_rd_data_valid = r_rd_valid;
   assign controller_busy     = r_busy;
   assign xfer_done           = r_done;
   assign ack_error           = r_ack_err;
   assign scl_oe              = r_scl_oe;
   assign sda_oe              = r_sda_oe;

endmodule
